// File: rtl/acc_pkg.sv
// Shared types and helpers for the byte-serial accumulator.
package acc_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ADD  = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int LANE_W = 8;

   // Operand byte presented to the adder for a given lane: lane 0 is the
   // operand itself, upper lanes are its zero or sign extension.
   function automatic logic [LANE_W-1:0] ext_lane(input logic [LANE_W-1:0] data,
                                                  input int                lane,
                                                  input logic              signed_mode);
      if (lane == 0) return data;
      return (signed_mode && data[LANE_W-1]) ? {LANE_W{1'b1}} : {LANE_W{1'b0}};
   endfunction

endpackage

// File: rtl/acc_byte_serial_rca_8.sv
// Combinational 8-bit ripple-carry adder used one byte lane at a time.
module rca_8 (
   input  logic [7:0] a,
   input  logic [7:0] b,
   input  logic       cin,
   output logic [7:0] s,
   output logic       cout
);

   logic [8:0] c;

   assign c[0] = cin;

   for (genvar g = 0; g < 8; g++) begin : g_fa
      assign s[g]   = a[g] ^ b[g] ^ c[g];
      assign c[g+1] = (a[g] & b[g]) | (c[g] & (a[g] ^ b[g]));
   end

   assign cout = c[8];

endmodule

// File: rtl/acc_byte_serial.sv
// Byte-serial accumulator: folds 8-bit operands into an ACC_BYTES-wide sum,
// one lane per cycle through rca_8. Define ACC_SIGNED_EN for two's-complement operands.
module acc_byte_serial
   import acc_pkg::*;
#(
   parameter int ACC_BYTES = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [7:0]               in_data,
   input  logic                     in_last,
   output logic                     sum_valid,
   input  logic                     sum_ready,
   output logic [8*ACC_BYTES-1:0]   sum_data,
   output logic                     sum_ovf
);

   localparam int              IDX_W   = (ACC_BYTES > 1) ? $clog2(ACC_BYTES) : 1;
   localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(ACC_BYTES - 1);

`ifdef ACC_SIGNED_EN
   localparam logic SIGNED_MODE = 1'b1;
`else
   localparam logic SIGNED_MODE = 1'b0;
`endif

   state_t                      state_q, state_d;
   logic [8*ACC_BYTES-1:0]      acc_q;
   logic [LANE_W-1:0]           op_q;
   logic                        last_q;
   logic [IDX_W-1:0]            idx_q;
   logic                        carry_q;
   logic                        ovf_q;

   logic [LANE_W-1:0]           a_lane, b_lane, add_s;
   logic                        add_cout;
   logic                        is_top;
   logic                        top_ovf;

   // Lane select for the shared adder.
   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      a_lane = '0;
      b_lane = '0;
      for (int i = 0; i < ACC_BYTES; i++) begin
         if (idx_q == IDX_W'(i)) begin
            a_lane = acc_q[i*LANE_W +: LANE_W];
            b_lane = ext_lane(op_q, i, SIGNED_MODE);
         end
      end
   end

   rca_8 u_rca (
      .a    (a_lane),
      .b    (b_lane),
      .cin  (carry_q),
      .s    (add_s),
      .cout (add_cout)
   );

   assign is_top = (idx_q == TOP_IDX);

`ifdef ACC_SIGNED_EN
   assign top_ovf = (a_lane[LANE_W-1] == b_lane[LANE_W-1]) &&
                    (add_s[LANE_W-1] != a_lane[LANE_W-1]);
`else
   assign top_ovf = add_cout;
`endif

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      in_ready  = 1'b0;
      sum_valid = 1'b0;
      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) state_d = ADD;
         end
         ADD: begin
            if (is_top) state_d = last_q ? OUT : IDLE;
         end
         OUT: begin
            sum_valid = 1'b1;
            if (sum_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q   <= '0;
         op_q    <= '0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         carry_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (in_valid) begin
                  op_q    <= in_data;
                  last_q  <= in_last;
                  idx_q   <= '0;
                  carry_q <= 1'b0;
               end
            end
            ADD: begin
               for (int i = 0; i < ACC_BYTES; i++) begin
                  if (idx_q == IDX_W'(i)) acc_q[i*LANE_W +: LANE_W] <= add_s;
               end
               carry_q <= add_cout;
               idx_q   <= idx_q + 1'b1;
               if (is_top) ovf_q <= ovf_q | top_ovf;
            end
            OUT: begin
               if (sum_ready) begin
                  acc_q <= '0;
                  ovf_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign sum_data = acc_q;
   assign sum_ovf  = ovf_q;

endmodule

// File: tb/tb_acc_byte_serial.sv
// Directed self-checking bench for acc_byte_serial with ACC_BYTES=2.
module tb_acc_byte_serial;

   localparam int ACC_BYTES = 2;

`ifdef ACC_SIGNED_EN
   localparam logic [15:0] EXP_FF01 = 16'h0000;
   localparam logic [15:0] EXP_258  = 16'hFEFE;
   localparam logic        OVF_258  = 1'b0;
`else
   localparam logic [15:0] EXP_FF01 = 16'h0100;
   localparam logic [15:0] EXP_258  = 16'h00FE;
   localparam logic        OVF_258  = 1'b1;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_data;
   logic        in_last;
   logic        sum_valid;
   logic        sum_ready;
   logic [15:0] sum_data;
   logic        sum_ovf;

   int errors = 0;
   int checks = 0;

   acc_byte_serial #(.ACC_BYTES(ACC_BYTES)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_last   (in_last),
      .sum_valid (sum_valid),
      .sum_ready (sum_ready),
      .sum_data  (sum_data),
      .sum_ovf   (sum_ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Called just after a falling edge; returns at the falling edge after the accept edge.
   task automatic send(input logic [7:0] d, input logic l);
      int n = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_last  = l;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) check("send_timeout", in_ready, 1);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!sum_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check(tag, sum_valid, 1);
   endtask

   task automatic get_result(input string tag, input logic [15:0] exp_d, input logic exp_o);
      wait_valid({tag, "_valid"});
      check({tag, "_data"}, sum_data, exp_d);
      check({tag, "_ovf"}, sum_ovf, exp_o);
      sum_ready = 1'b1;
      @(negedge clk);
      sum_ready = 1'b0;
      check({tag, "_rdy_after"}, in_ready, 1);
      check({tag, "_vld_after"}, sum_valid, 0);
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_data = '0; in_last = 1'b0; sum_ready = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      check("rst_sum_valid", sum_valid, 0);
      check("rst_sum_data", sum_data, 0);
      check("rst_sum_ovf", sum_ovf, 0);
      rst = 1'b0;
      @(negedge clk);

      // Carry out of lane 0 into lane 1, with result latency.
      send(8'hFF, 1'b0);
      send(8'h01, 1'b1);
      check("lat_e0", sum_valid, 0);
      @(negedge clk);
      check("lat_e1", sum_valid, 0);
      @(negedge clk);
      check("lat_e2", sum_valid, 1);
      get_result("ff01", EXP_FF01, 1'b0);

      // Long frame wraps the accumulator.
      for (int i = 0; i < 257; i++) send(8'hFF, 1'b0);
      send(8'hFF, 1'b1);
      get_result("wrap258", EXP_258, OVF_258);

`ifdef ACC_SIGNED_EN
      send(8'h80, 1'b0);
      send(8'h80, 1'b1);
      get_result("sgn8080", 16'hFF00, 1'b0);
`endif

      // Result backpressure with an operand waiting.
      send(8'h12, 1'b0);
      send(8'h34, 1'b1);
      wait_valid("bp_valid");
      in_valid = 1'b1; in_data = 8'h77; in_last = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_data", sum_data, 16'h0046);
         check("bp_in_ready", in_ready, 0);
         check("bp_sum_valid", sum_valid, 1);
      end
      sum_ready = 1'b1;
      @(negedge clk);
      sum_ready = 1'b0;
      check("bp_rel_ready", in_ready, 1);
      check("bp_rel_data", sum_data, 0);
      @(negedge clk);
      in_valid = 1'b0; in_last = 1'b0;
      check("bp_next_busy", in_ready, 0);
      get_result("bp_next", 16'h0077, 1'b0);

      // Asynchronous reset between lane edges E1 and E2.
      send(8'h40, 1'b0);
      send(8'h20, 1'b0);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("mid_rst_in_ready", in_ready, 1);
      check("mid_rst_sum_valid", sum_valid, 0);
      check("mid_rst_sum_data", sum_data, 0);
      check("mid_rst_sum_ovf", sum_ovf, 0);
      @(negedge clk);
      rst = 1'b0;
      send(8'h05, 1'b1);
      get_result("post_rst", 16'h0005, 1'b0);

      // Single zero operand; result held until accepted.
      send(8'h00, 1'b1);
      wait_valid("zero_valid");
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("zero_hold", sum_valid, 1);
      end
      get_result("zero", 16'h0000, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
